write_buffer_mc_controller: RTL and testbench

Multi-channel successor of the single-channel write-buffer controller. Accepts completed partial results from `NUM_CH` independent producers, holds each in a one-entry per-channel slot, and drains the slots into the shared output buffer through a round-robin arbiter under the buffer's `ready` handshake. Sits between the PE/accumulator array and the output buffer. Back-pressure to each producer is reported per channel; lost results are flagged.

---
 rtl/write_buffer_mc_controller_pkg.sv | 27 ++
 rtl/write_buffer_mc_controller_rr_arbiter.sv | 46 ++++
 rtl/write_buffer_mc_controller.sv | 102 ++++++++++
 tb/tb_write_buffer_mc_controller.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/write_buffer_mc_controller_pkg.sv
// Shared definitions for the multi-channel write-buffer controller:
// index-width helper, per-channel slot record and reset constants.
package write_buffer_mc_controller_pkg;

    // Width of one buffered partial result; the slot record is sized by it.
    localparam int SLOT_DATA_W = 16;

    // Bits needed to encode a channel index (never less than one bit).
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // One-entry holding slot per producer channel.
    typedef struct packed {
        logic                   valid;
        logic [SLOT_DATA_W-1:0] data;
    } slot_t;

    localparam slot_t SLOT_RESET      = '{valid: 1'b0, data: '0};
    localparam logic  WR_STROBE_RESET = 1'b0;

    // last_grant starts at the highest index so channel 0 wins first.
    function automatic int last_grant_reset(input int num_ch);
        return num_ch - 1;
    endfunction

endpackage

// File: rtl/write_buffer_mc_controller_rr_arbiter.sv
// Round-robin arbiter: picks the first requesting channel after the
// previously granted one, and remembers the winner.
module rr_arbiter
    import write_buffer_mc_controller_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              en,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              gnt_valid
);

    logic [IDX_W-1:0] last_grant;

    // Rotating search starting one past the last winner; first hit wins.
    always_comb begin
        int idx;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        for (int off = 1; off <= NUM_CH; off++) begin
            idx = (int'(last_grant) + off) % NUM_CH;
            if (en && !gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt[idx]  = 1'b1;
                gnt_idx   = IDX_W'(idx);
            end
        end
    end

    // Remember the winner; hold the pointer when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= IDX_W'(last_grant_reset(NUM_CH));
        end else if (gnt_valid) begin
            last_grant <= gnt_idx;
        end
    end

endmodule

// File: rtl/write_buffer_mc_controller.sv
// Multi-channel write-buffer controller: one holding slot per producer,
// drained round-robin into the shared output buffer under its ready
// handshake, with per-channel back-pressure and sticky loss flags.
module write_buffer_mc_controller
    import write_buffer_mc_controller_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = SLOT_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NUM_CH-1:0]          par_done,
    input  logic [NUM_CH*DATA_W-1:0]   par_data,
    input  logic                       ready,
    output logic                       write_in_buffer,
    output logic [DATA_W-1:0]          wr_data,
    output logic [ch_idx_w(NUM_CH)-1:0] wr_ch,
    output logic [NUM_CH-1:0]          stall_output_buffer,
    output logic [NUM_CH-1:0]          overflow,
    output logic                       idle
);

    localparam int CH_IDX_W = ch_idx_w(NUM_CH);

    // Slot data width follows the package record; DATA_W must match it.
    slot_t               slots [NUM_CH];
    logic [NUM_CH-1:0]   hold_valid;
    logic [NUM_CH-1:0]   gnt;
    logic [CH_IDX_W-1:0] gnt_idx;
    logic                gnt_valid;

    // Gather slot valid bits; these are both the requests and the stalls.
    always_comb begin
        hold_valid = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hold_valid[i] = slots[i].valid;
        end
    end

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (CH_IDX_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (hold_valid),
        .en        (ready),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Slot update: capture when empty or being drained this cycle, else
    // clear a granted slot; a full, ungranted slot ignores new results.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                slots[i] <= SLOT_RESET;
            end else if (start && par_done[i] && (!slots[i].valid || gnt[i])) begin
                slots[i].valid <= 1'b1;
                slots[i].data  <= par_data[i*DATA_W +: DATA_W];
            end else if (gnt[i]) begin
                slots[i].valid <= 1'b0;
            end
        end
    end

    // Sticky loss flags: a result arriving at a full slot that is not
    // being drained in the same cycle is dropped and remembered.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                overflow[i] <= 1'b0;
            end else if (start && par_done[i] && slots[i].valid && !gnt[i]) begin
                overflow[i] <= 1'b1;
            end
        end
    end

    // Registered write stage; data and channel hold when no grant occurs.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_in_buffer <= WR_STROBE_RESET;
            wr_data         <= '0;
            wr_ch           <= '0;
        end else begin
            write_in_buffer <= gnt_valid;
            if (gnt_valid) begin
                wr_data <= slots[gnt_idx].data;
                wr_ch   <= gnt_idx;
            end
        end
    end

    // Status outputs derived from registered state only.
    always_comb begin
        stall_output_buffer = hold_valid;
        idle                = ~|hold_valid & ~write_in_buffer;
    end

endmodule

// File: tb/tb_write_buffer_mc_controller.sv
// Directed self-checking bench for write_buffer_mc_controller.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_write_buffer_mc_controller;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 16;

    logic                     clk;
    logic                     rst;
    logic                     start;
    logic [NUM_CH-1:0]        par_done;
    logic [NUM_CH*DATA_W-1:0] par_data;
    logic                     ready;
    logic                     write_in_buffer;
    logic [DATA_W-1:0]        wr_data;
    logic [1:0]               wr_ch;
    logic [NUM_CH-1:0]        stall_output_buffer;
    logic [NUM_CH-1:0]        overflow;
    logic                     idle;

    int tests_run;
    int tests_failed;

    write_buffer_mc_controller #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .par_done            (par_done),
        .par_data            (par_data),
        .ready               (ready),
        .write_in_buffer     (write_in_buffer),
        .wr_data             (wr_data),
        .wr_ch               (wr_ch),
        .stall_output_buffer (stall_output_buffer),
        .overflow            (overflow),
        .idle                (idle)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic setData(input int ch, input logic [DATA_W-1:0] val);
        par_data[ch*DATA_W +: DATA_W] = val;
    endtask

    task automatic applyReset();
        rst      = 1'b1;
        par_done = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic checkWrite(input string tag, input logic [1:0] ch,
                              input logic [DATA_W-1:0] data);
        checkOutput({tag, "_wr"},   32'(write_in_buffer), 32'd1);
        checkOutput({tag, "_ch"},   32'(wr_ch),           32'(ch));
        checkOutput({tag, "_data"}, 32'(wr_data),         32'(data));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b1;
        start    = 1'b0;
        par_done = '0;
        par_data = '0;
        ready    = 1'b0;

        // Reset values and ignored strobe while start is low.
        applyReset();
        checkOutput("rst_wr",    32'(write_in_buffer),     32'd0);
        checkOutput("rst_data",  32'(wr_data),             32'd0);
        checkOutput("rst_ch",    32'(wr_ch),               32'd0);
        checkOutput("rst_stall", 32'(stall_output_buffer), 32'd0);
        checkOutput("rst_ovf",   32'(overflow),            32'd0);
        checkOutput("rst_idle",  32'(idle),                32'd1);
        ready    = 1'b1;
        par_done = 4'b0001;
        setData(0, 16'h5555);
        tick();
        par_done = '0;
        checkOutput("nostart_stall", 32'(stall_output_buffer), 32'd0);
        tick();
        checkOutput("nostart_wr",  32'(write_in_buffer), 32'd0);
        checkOutput("nostart_ovf", 32'(overflow),        32'd0);

        // Single channel latency.
        start    = 1'b1;
        par_done = 4'b0100;
        setData(2, 16'h00A5);
        tick();
        par_done = '0;
        checkOutput("single_stall", 32'(stall_output_buffer), 32'h4);
        checkOutput("single_nowr",  32'(write_in_buffer),     32'd0);
        tick();
        checkWrite("single", 2'd2, 16'h00A5);
        checkOutput("single_stall_clr", 32'(stall_output_buffer), 32'd0);
        tick();
        checkOutput("single_idle", 32'(idle), 32'd1);

        // Round-robin from reset pointer: ch0..ch3 on consecutive cycles.
        applyReset();
        start    = 1'b1;
        ready    = 1'b1;
        par_done = 4'b1111;
        for (int k = 0; k < NUM_CH; k++) setData(k, 16'(16'h10 + k));
        tick();
        par_done = '0;
        checkOutput("rr_stall", 32'(stall_output_buffer), 32'hF);
        for (int k = 0; k < NUM_CH; k++) begin
            tick();
            checkWrite($sformatf("rr%0d", k), 2'(k), 16'(16'h10 + k));
        end
        checkOutput("rr_busy", 32'(idle), 32'd0);
        tick();
        checkOutput("rr_idle", 32'(idle), 32'd1);

        // Back-pressure: slots 1 and 3 wait, then drain ch1 then ch3.
        ready    = 1'b0;
        par_done = 4'b1010;
        setData(1, 16'h0021);
        setData(3, 16'h0023);
        tick();
        par_done = '0;
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("bp_nowr%0d", k),  32'(write_in_buffer),     32'd0);
            checkOutput($sformatf("bp_stall%0d", k), 32'(stall_output_buffer), 32'hA);
            tick();
        end
        ready = 1'b1;
        tick();
        checkWrite("bp_first", 2'd1, 16'h0021);
        tick();
        checkWrite("bp_second", 2'd3, 16'h0023);
        tick();
        checkOutput("bp_done", 32'(write_in_buffer), 32'd0);

        // Overflow on ch0, same-cycle refill of ch1 without loss.
        ready    = 1'b0;
        par_done = 4'b0011;
        setData(0, 16'h1234);
        setData(1, 16'h0111);
        tick();
        par_done = 4'b0001;
        setData(0, 16'hBEEF);
        tick();
        par_done = '0;
        checkOutput("ovf_flag",  32'(overflow),            32'h1);
        checkOutput("ovf_stall", 32'(stall_output_buffer), 32'h3);
        ready = 1'b1;
        tick();
        checkWrite("ovf_orig", 2'd0, 16'h1234);
        par_done = 4'b0010;
        setData(1, 16'h0222);
        tick();
        par_done = '0;
        checkWrite("refill_old", 2'd1, 16'h0111);
        checkOutput("refill_stall", 32'(stall_output_buffer), 32'h2);
        tick();
        checkWrite("refill_new", 2'd1, 16'h0222);
        checkOutput("refill_ovf", 32'(overflow), 32'h1);
        tick();
        checkOutput("refill_idle", 32'(idle), 32'd1);

        // Reset mid-drain: pointer is at ch1, so ch2 drains first.
        ready    = 1'b0;
        par_done = 4'b0111;
        setData(0, 16'h0031);
        setData(1, 16'h0032);
        setData(2, 16'h0033);
        tick();
        par_done = '0;
        ready    = 1'b1;
        tick();
        checkWrite("mid_pre", 2'd2, 16'h0033);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_wr",    32'(write_in_buffer),     32'd0);
        checkOutput("mid_stall", 32'(stall_output_buffer), 32'd0);
        checkOutput("mid_ovf",   32'(overflow),            32'd0);
        tick();
        checkOutput("mid_nowr", 32'(write_in_buffer), 32'd0);
        checkOutput("mid_idle", 32'(idle),            32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
